// File: rtl/alu_dispatch_if.sv
// Shared ALU command/response types and the request/result stream interface of alu_dispatch.
package alu_dispatch_pkg;
  typedef enum logic [1:0] {NOP = 2'd0, ADD = 2'd1, MULTIPLY = 2'd2, AND = 2'd3} command_names_t;
  typedef enum logic [1:0] {NO_RESPONSE = 2'd0, SUCCESS = 2'd1, OVERFLOW = 2'd2} response_names_t;

  typedef struct packed {
    command_names_t command;
    logic [31:0]    data1;
    logic [31:0]    data2;
  } input_packet_t;

  typedef struct packed {
    response_names_t response;
    logic [31:0]     data;
  } output_packet_t;
endpackage

interface alu_dispatch_if;
  import alu_dispatch_pkg::*;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_bank;
  command_names_t  req_command;
  logic [31:0]     req_data1;
  logic [31:0]     req_data2;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_bank;
  response_names_t rsp_response;
  logic [31:0]     rsp_data;
  logic            rsp_timeout;

  modport master (output req_valid, req_bank, req_command, req_data1, req_data2, rsp_ready,
                  input  req_ready, rsp_valid, rsp_bank, rsp_response, rsp_data, rsp_timeout);
  modport slave  (input  req_valid, req_bank, req_command, req_data1, req_data2, rsp_ready,
                  output req_ready, rsp_valid, rsp_bank, rsp_response, rsp_data, rsp_timeout);
endinterface

// File: rtl/alu_dispatch.sv
// Dispatches requests to four independent ALU banks and serializes their results
// through a round-robin arbiter; each bank runs IDLE -> ISSUE -> WAIT -> DONE.
module alu_dispatch_bank
  import alu_dispatch_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            accept,
  input  command_names_t  cmd,
  input  logic [31:0]     data1,
  input  logic [31:0]     data2,
  input  output_packet_t  alu_rsp,
  input  logic            release_bank,
  output logic            idle,
  output logic            done,
  output input_packet_t   issue,
  output response_names_t cap_response,
  output logic [31:0]     cap_data,
  output logic            cap_timeout
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  input_packet_t   pkt_q, pkt_d;
  response_names_t resp_q, resp_d;
  logic [31:0]     data_q, data_d;
  logic            to_q, to_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pkt_d         = pkt_q;
    pkt_d.command = NOP;  // command is live only during ISSUE; operands persist
    resp_d        = resp_q;
    data_d        = data_q;
    to_d          = to_q;
    case (state_q)
      IDLE:  if (accept) begin
               state_d = ISSUE;
               pkt_d   = '{command: cmd, data1: data1, data2: data2};
             end
      ISSUE: begin
               state_d = WAIT;
               cnt_d   = '0;
             end
      WAIT:  if (alu_rsp.response != NO_RESPONSE) begin
               state_d = DONE;
               resp_d  = alu_rsp.response;
               data_d  = alu_rsp.data;
               to_d    = 1'b0;
             end else if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               resp_d  = NO_RESPONSE;
               data_d  = '0;
               to_d    = 1'b1;
             end else begin
               cnt_d = cnt_q + 1'b1;
             end
      DONE:  if (release_bank) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pkt_q   <= '0;
      resp_q  <= NO_RESPONSE;
      data_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      to_q    <= to_d;
    end
  end

  assign idle         = (state_q == IDLE);
  assign done         = (state_q == DONE);
  assign issue        = pkt_q;
  assign cap_response = resp_q;
  assign cap_data     = data_q;
  assign cap_timeout  = to_q;
endmodule

module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_dispatch_if.slave        bus,
  output input_packet_t  [3:0] input_packet,
  input  output_packet_t [3:0] output_packet,
  output logic           [3:0] busy
);
  localparam int NUM_BANKS = 4;

  logic [NUM_BANKS-1:0]             idle, done, accept, release_bank, cap_timeout;
  response_names_t [NUM_BANKS-1:0]  cap_response;
  logic [NUM_BANKS-1:0][31:0]       cap_data;
  logic [1:0]                       ptr_q, ptr_d, lock_bank_q, lock_bank_d, gnt;
  logic                             lock_q, lock_d, hs;

  assign bus.req_ready = idle[bus.req_bank];
  assign busy          = ~idle;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign accept[b]       = bus.req_valid && bus.req_ready && (bus.req_command != NOP)
                             && (bus.req_bank == 2'(b));
    assign release_bank[b] = hs && (gnt == 2'(b));
    alu_dispatch_bank #(.TIMEOUT(TIMEOUT)) u_bank (
      .clock        (clock),
      .reset        (reset),
      .accept       (accept[b]),
      .cmd          (bus.req_command),
      .data1        (bus.req_data1),
      .data2        (bus.req_data2),
      .alu_rsp      (output_packet[b]),
      .release_bank (release_bank[b]),
      .idle         (idle[b]),
      .done         (done[b]),
      .issue        (input_packet[b]),
      .cap_response (cap_response[b]),
      .cap_data     (cap_data[b]),
      .cap_timeout  (cap_timeout[b])
    );
  end

  // Lowest offset from the pointer wins; a stalled grant is held so rsp_* stay stable.
  always_comb begin
    gnt = ptr_q;
    for (int i = NUM_BANKS - 1; i >= 0; i--)
      if (done[ptr_q + 2'(i)]) gnt = ptr_q + 2'(i);
    if (lock_q) gnt = lock_bank_q;
  end

  assign bus.rsp_valid    = |done;
  assign hs               = bus.rsp_valid && bus.rsp_ready;
  assign bus.rsp_bank     = bus.rsp_valid ? gnt : 2'd0;
  assign bus.rsp_response = bus.rsp_valid ? cap_response[gnt] : NO_RESPONSE;
  assign bus.rsp_data     = bus.rsp_valid ? cap_data[gnt] : 32'd0;
  assign bus.rsp_timeout  = bus.rsp_valid && cap_timeout[gnt];

  always_comb begin
    ptr_d       = hs ? gnt + 2'd1 : ptr_q;
    lock_d      = bus.rsp_valid && !bus.rsp_ready;
    lock_bank_d = gnt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q       <= 2'd0;
      lock_q      <= 1'b0;
      lock_bank_q <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_bank_q <= lock_bank_d;
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: table of single-op vectors, directed multi-bank sequences,
// then randomized traffic against a transaction-level reference model.
module tb_alu_dispatch;
  import alu_dispatch_pkg::*;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  alu_dispatch_if bus();
  input_packet_t  [3:0] input_packet;
  output_packet_t [3:0] output_packet;
  logic [3:0] busy;
  int n_tests = 0;
  int n_fail  = 0;

  alu_dispatch #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .input_packet(input_packet), .output_packet(output_packet), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] bank; command_names_t cmd; logic [31:0] a; logic [31:0] b;
    int dly; response_names_t alu_r; logic [31:0] alu_d;
    int exp_k; response_names_t exp_r; logic [31:0] exp_d; logic exp_to;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    bus.req_valid = 1'b0; bus.req_bank = 2'd0; bus.req_command = NOP;
    bus.req_data1 = '0; bus.req_data2 = '0; bus.rsp_ready = 1'b0;
    output_packet = '0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic send(input logic [1:0] b, input command_names_t c, input logic [31:0] a, input logic [31:0] x);
    bus.req_valid = 1'b1; bus.req_bank = b; bus.req_command = c;
    bus.req_data1 = a; bus.req_data2 = x;
    #1 chk("send_ready", bus.req_ready, 1'b1);
    step();
    bus.req_valid = 1'b0; bus.req_command = NOP;
  endtask

  task automatic respond(input logic [3:0] mask, input logic [31:0] base);
    for (int b = 0; b < 4; b++)
      if (mask[b]) output_packet[b] = '{SUCCESS, base + 32'(b)};
    step();
    output_packet = '0;
  endtask

  task automatic chk_rsp(input string n, input logic [1:0] b, input response_names_t r,
                         input logic [31:0] d, input logic t);
    chk({n, "_valid"}, bus.rsp_valid, 1'b1);
    chk({n, "_bank"}, bus.rsp_bank, b);
    chk({n, "_resp"}, bus.rsp_response, r);
    chk({n, "_data"}, bus.rsp_data, d);
    chk({n, "_timeout"}, bus.rsp_timeout, t);
  endtask

  // reference-model state for the random phase
  logic [3:0] mbusy, mdone;
  int iss[4], dn[4], rc[4];
  command_names_t icmd[4];
  logic [31:0] la[4], lb[4];
  output_packet_t alu[4], expd[4];
  logic eto[4];
  int ptr, g, lbank, d, ab, k;
  bit locked, hs, acc, got, found;
  logic [1:0] rr;

  initial begin
    vecs[0] = '{2'd1, ADD,      32'd5,     32'd7,  4, SUCCESS,  32'd12,        5, SUCCESS,     32'd12,   1'b0};
    vecs[1] = '{2'd0, MULTIPLY, 32'd3,     32'd4,  0, SUCCESS,  32'd12,       17, NO_RESPONSE, 32'd0,    1'b1};
    vecs[2] = '{2'd0, AND,      32'hf0,    32'h3c, 16, SUCCESS, 32'h30,       17, SUCCESS,     32'h30,   1'b0};
    vecs[3] = '{2'd2, MULTIPLY, 32'hffffffff, 32'd2, 17, OVERFLOW, 32'hfffffffe, 17, NO_RESPONSE, 32'd0, 1'b1};
    vecs[4] = '{2'd3, ADD,      32'hffffffff, 32'd1, 1, OVERFLOW, 32'd0,       2, OVERFLOW,    32'd0,    1'b0};
    vecs[5] = '{2'd2, AND,      32'd7,     32'hf,  15, SUCCESS, 32'd7,        16, SUCCESS,     32'd7,    1'b0};

    do_reset();
    #1;
    chk("rst_ipkt", input_packet == '0, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_fields", {bus.rsp_bank, bus.rsp_response, bus.rsp_data, bus.rsp_timeout}, 0);
    chk("rst_busy", busy, 4'b0000);
    chk("rst_ready", bus.req_ready, 1'b1);

    // single-op vectors: issue, ALU answer after dly cycles (0 = never), collect result
    foreach (vecs[i]) begin
      send(vecs[i].bank, vecs[i].cmd, vecs[i].a, vecs[i].b);
      #1 chk("issue_cmd", input_packet[vecs[i].bank].command, vecs[i].cmd);
      chk("issue_ops", {input_packet[vecs[i].bank].data1, input_packet[vecs[i].bank].data2},
          {vecs[i].a, vecs[i].b});
      got = 1'b0; k = 0;
      while (!got && k < 40) begin
        step(); k++;
        if (k == vecs[i].dly) output_packet[vecs[i].bank] = '{vecs[i].alu_r, vecs[i].alu_d};
        else output_packet[vecs[i].bank] = '0;
        #1;
        if (k == 1) chk("issue_one_cycle", input_packet[vecs[i].bank].command, NOP);
        got = bus.rsp_valid;
      end
      chk("vec_latency", k, vecs[i].exp_k);
      chk_rsp("vec", vecs[i].bank, vecs[i].exp_r, vecs[i].exp_d, vecs[i].exp_to);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0; output_packet = '0;
      #1 chk("vec_released", busy, 4'b0000);
      chk("vec_drained", bus.rsp_valid, 1'b0);
    end

    // busy bank rejects, a different bank in the same cycle is accepted
    send(2'd2, ADD, 32'd1, 32'd2);
    step();
    bus.req_valid = 1'b1; bus.req_bank = 2'd2; bus.req_command = MULTIPLY;
    #1 chk("busy_reject", bus.req_ready, 1'b0);
    bus.req_bank = 2'd3;
    #1 chk("other_bank_ready", bus.req_ready, 1'b1);
    step();
    bus.req_valid = 1'b0;
    #1 chk("both_busy", busy, 4'b1100);
    chk("bank3_issue", input_packet[3].command, MULTIPLY);
    do_reset();

    // all four answer on one edge: served 0,1,2,3 back to back
    for (int b = 0; b < 4; b++) send(2'(b), ADD, 32'(b), 32'd1);
    step();
    respond(4'hf, 32'd100);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_rsp("arb", 2'(i), SUCCESS, 32'd100 + 32'(i), 1'b0);
      step();
    end
    #1 chk("arb_empty", bus.rsp_valid, 1'b0);
    bus.rsp_ready = 1'b0;
    // pointer wrapped to 0: bank 0 beats bank 3
    send(2'd3, ADD, 32'd1, 32'd1);
    send(2'd0, ADD, 32'd1, 32'd1);
    step();
    respond(4'b1001, 32'd300);
    bus.req_bank = 2'd0;
    #1 chk("done_not_ready", bus.req_ready, 1'b0);
    bus.rsp_ready = 1'b1;
    #1 chk_rsp("pass2_first", 2'd0, SUCCESS, 32'd300, 1'b0);
    step();
    #1 chk("ready_after_release", bus.req_ready, 1'b1);
    chk_rsp("pass2_second", 2'd3, SUCCESS, 32'd303, 1'b0);
    step();
    bus.rsp_ready = 1'b0;
    do_reset();

    // backpressure: grant on bank 1 holds even when bank 0 finishes meanwhile
    for (int b = 0; b < 3; b++) send(2'(b), AND, 32'd1, 32'd1);
    step();
    respond(4'b0110, 32'd200);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) output_packet[0] = '{SUCCESS, 32'd200};
      else output_packet[0] = '0;
      #1 chk_rsp("bp_hold", 2'd1, SUCCESS, 32'd201, 1'b0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1 chk_rsp("bp_first", 2'd1, SUCCESS, 32'd201, 1'b0);
    step();
    #1 chk_rsp("bp_second", 2'd2, SUCCESS, 32'd202, 1'b0);
    step();
    #1 chk_rsp("bp_third", 2'd0, SUCCESS, 32'd200, 1'b0);
    step();
    bus.rsp_ready = 1'b0;
    #1 chk("bp_empty", bus.rsp_valid, 1'b0);

    // reset mid-operation with banks 0 and 3 waiting
    do_reset();
    send(2'd0, ADD, 32'd9, 32'd9);
    send(2'd3, AND, 32'd5, 32'd6);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #1 chk("midrst_ipkt", input_packet == '0, 1'b1);
    chk("midrst_busy", busy, 4'b0000);
    chk("midrst_valid", bus.rsp_valid, 1'b0);
    output_packet[0] = '{SUCCESS, 32'd55};
    output_packet[3] = '{OVERFLOW, 32'd66};
    for (int i = 0; i < 4; i++) begin
      step();
      #1 chk("post_rst_quiet", {bus.rsp_valid, busy}, 5'b0);
    end
    output_packet = '0;
    bus.req_valid = 1'b1; bus.req_bank = 2'd0; bus.req_command = NOP; bus.req_data1 = 32'd77;
    #1 chk("nop_ready", bus.req_ready, 1'b1);
    step();
    bus.req_valid = 1'b0;
    #1 chk("nop_no_issue", input_packet == '0, 1'b1);
    chk("nop_not_busy", busy, 4'b0000);

    // randomized traffic against the transaction-level model
    do_reset();
    mbusy = '0; ptr = 0; locked = 1'b0; lbank = 0;
    for (int b = 0; b < 4; b++) begin
      la[b] = '0; lb[b] = '0; iss[b] = -5; dn[b] = 0; rc[b] = -1;
      icmd[b] = NOP; alu[b] = '0; expd[b] = '0; eto[b] = 1'b0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        mdone[b] = mbusy[b] && (c > dn[b]);
        rr = 2'($urandom_range(0, 2));
        if (mbusy[b] && c == rc[b]) output_packet[b] = alu[b];
        else if (!mbusy[b] || c == iss[b] || mdone[b]) output_packet[b].response = response_names_t'(rr);
        else output_packet[b].response = NO_RESPONSE;
        if (!(mbusy[b] && c == rc[b])) output_packet[b].data = $urandom;
      end
      bus.req_valid   = ($urandom_range(0, 1) == 1);
      bus.req_bank    = 2'($urandom_range(0, 3));
      bus.req_command = command_names_t'(2'($urandom_range(0, 3)));
      bus.req_data1   = $urandom;
      bus.req_data2   = $urandom;
      bus.rsp_ready   = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_ready", bus.req_ready, !mbusy[bus.req_bank]);
      chk("rnd_busy", busy, mbusy);
      for (int b = 0; b < 4; b++) begin
        chk("rnd_cmd", input_packet[b].command, (mbusy[b] && c == iss[b]) ? icmd[b] : NOP);
        chk("rnd_ops", {input_packet[b].data1, input_packet[b].data2}, {la[b], lb[b]});
      end
      chk("rnd_valid", bus.rsp_valid, |mdone);
      g = lbank;
      if (!locked) begin
        found = 1'b0;
        for (int i = 0; i < 4; i++)
          if (!found && mdone[(ptr + i) % 4]) begin g = (ptr + i) % 4; found = 1'b1; end
      end
      if (|mdone) begin
        chk("rnd_bank", bus.rsp_bank, g);
        chk("rnd_result", {bus.rsp_response, bus.rsp_data, bus.rsp_timeout},
            {expd[g].response, expd[g].data, eto[g]});
      end
      hs     = (|mdone) && bus.rsp_ready;
      locked = (|mdone) && !bus.rsp_ready;
      lbank  = g;
      acc    = bus.req_valid && !mbusy[bus.req_bank] && (bus.req_command != NOP);
      ab     = int'(bus.req_bank);
      if (acc) begin
        icmd[ab] = bus.req_command; la[ab] = bus.req_data1; lb[ab] = bus.req_data2;
      end
      step();
      if (hs) begin
        mbusy[g] = 1'b0;
        ptr = (g + 1) % 4;
      end
      if (acc) begin
        d = $urandom_range(1, TO + 6);
        mbusy[ab] = 1'b1;
        iss[ab] = c + 1;
        alu[ab].response = ($urandom_range(0, 1) == 1) ? SUCCESS : OVERFLOW;
        alu[ab].data = $urandom;
        if (d <= TO) begin
          rc[ab] = c + 1 + d; dn[ab] = c + 1 + d; expd[ab] = alu[ab]; eto[ab] = 1'b0;
        end else begin
          rc[ab] = -1; dn[ab] = c + 1 + TO; expd[ab] = '{NO_RESPONSE, 32'd0}; eto[ab] = 1'b1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
